// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Two-requester round-robin arbiter onto a single memory bus,
//            with per-transaction timeout and registered response data.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_lanes,
  input  logic [31:0] m0_dout,
  input  logic        m0_wr,
  input  logic        m0_valid,
  output logic [31:0] m0_din,
  output logic        m0_ready,
  output logic        m0_err,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_lanes,
  input  logic [31:0] m1_dout,
  input  logic        m1_wr,
  input  logic        m1_valid,
  output logic [31:0] m1_din,
  output logic        m1_ready,
  output logic        m1_err,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_lanes,
  output logic [31:0] bus_dout,
  output logic        bus_wr,
  output logic        bus_valid,
  input  logic [31:0] bus_din,
  input  logic        bus_ready
);

  localparam int c_CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  // Counter holds completed BUSY cycles, so the last allowed cycle is TIMEOUT-1.
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_gnt;
  logic                 r_last;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [31:0]          r_din0;
  logic [31:0]          r_din1;
  logic                 r_err0;
  logic                 r_err1;
  logic                 w_grant;
  logic                 w_done_ok;
  logic                 w_done_tmo;
  logic                 w_busy;

  always_comb begin
    w_next     = r_state;
    w_grant    = r_gnt;
    w_done_ok  = 1'b0;
    w_done_tmo = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (m0_valid || m1_valid) begin
          w_next  = S_BUSY;
          w_grant = (m0_valid && m1_valid) ? ~r_last : m1_valid;
        end
      end
      S_BUSY: begin
        if (bus_ready) begin
          w_next    = S_RESP;
          w_done_ok = 1'b1;
        end else if (r_cnt == c_CNT_LAST) begin
          w_next     = S_RESP;
          w_done_tmo = 1'b1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_din0  <= '0;
      r_din1  <= '0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_BUSY) begin
        r_gnt  <= w_grant;
        r_last <= w_grant;
        r_cnt  <= '0;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Response data is captured even for writes; the requester ignores it.
      if (w_done_ok || w_done_tmo) begin
        if (r_gnt) begin
          r_din1 <= w_done_ok ? bus_din : 32'd0;
          r_err1 <= w_done_tmo;
        end else begin
          r_din0 <= w_done_ok ? bus_din : 32'd0;
          r_err0 <= w_done_tmo;
        end
      end
    end
  end

  assign w_busy    = (r_state == S_BUSY);
  assign bus_valid = w_busy;
  assign bus_addr  = w_busy ? (r_gnt ? m1_addr  : m0_addr)  : 32'd0;
  assign bus_lanes = w_busy ? (r_gnt ? m1_lanes : m0_lanes) : 4'd0;
  assign bus_dout  = w_busy ? (r_gnt ? m1_dout  : m0_dout)  : 32'd0;
  assign bus_wr    = w_busy ? (r_gnt ? m1_wr    : m0_wr)    : 1'b0;

  assign m0_ready = (r_state == S_RESP) && !r_gnt;
  assign m1_ready = (r_state == S_RESP) &&  r_gnt;
  assign m0_din   = r_din0;
  assign m1_din   = r_din1;
  assign m0_err   = r_err0;
  assign m1_err   = r_err1;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Directed and randomized self-checking bench for bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] m_addr [2];
  logic [3:0]  m_lanes[2];
  logic [31:0] m_dout [2];
  logic        m_wr   [2];
  logic        m_valid[2];
  logic [31:0] d_din  [2];
  logic        d_ready[2];
  logic        d_err  [2];
  logic [31:0] bus_addr, bus_dout, bus_din;
  logic [3:0]  bus_lanes;
  logic        bus_wr, bus_valid, bus_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: transaction phase (0 idle, 1 on bus, 2 responding).
  int          ph, own, lst, el;
  logic [31:0] mdin[2];
  logic        merr[2];
  logic        rdy_seen[2];
  bit          chk_on = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m_addr[0]), .m0_lanes(m_lanes[0]), .m0_dout(m_dout[0]),
    .m0_wr(m_wr[0]), .m0_valid(m_valid[0]),
    .m0_din(d_din[0]), .m0_ready(d_ready[0]), .m0_err(d_err[0]),
    .m1_addr(m_addr[1]), .m1_lanes(m_lanes[1]), .m1_dout(m_dout[1]),
    .m1_wr(m_wr[1]), .m1_valid(m_valid[1]),
    .m1_din(d_din[1]), .m1_ready(d_ready[1]), .m1_err(d_err[1]),
    .bus_addr(bus_addr), .bus_lanes(bus_lanes), .bus_dout(bus_dout),
    .bus_wr(bus_wr), .bus_valid(bus_valid),
    .bus_din(bus_din), .bus_ready(bus_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      ph = 0; own = 0; lst = 1; el = 0;
      for (int n = 0; n < 2; n++) begin mdin[n] = 32'd0; merr[n] = 1'b0; end
    end
    if (chk_on) begin
      check("bus_valid", 32'(bus_valid), 32'(ph == 1));
      check("bus_addr",  bus_addr,          (ph == 1) ? m_addr[own] : 32'd0);
      check("bus_lanes", 32'(bus_lanes),    (ph == 1) ? 32'(m_lanes[own]) : 32'd0);
      check("bus_dout",  bus_dout,          (ph == 1) ? m_dout[own] : 32'd0);
      check("bus_wr",    32'(bus_wr),       (ph == 1) ? 32'(m_wr[own]) : 32'd0);
      for (int n = 0; n < 2; n++) begin
        check($sformatf("m%0d_ready", n), 32'(d_ready[n]), 32'(ph == 2 && own == n));
        check($sformatf("m%0d_din", n),   d_din[n], mdin[n]);
        check($sformatf("m%0d_err", n),   32'(d_err[n]), 32'(merr[n]));
      end
    end
    for (int n = 0; n < 2; n++) rdy_seen[n] = (ph == 2 && own == n);
    if (rst) begin
      case (ph)
        0: if (m_valid[0] || m_valid[1]) begin
             own = (m_valid[0] && m_valid[1]) ? 1 - lst : (m_valid[1] ? 1 : 0);
             lst = own; el = 0; ph = 1;
           end
        1: begin
             el++;
             if (bus_ready) begin mdin[own] = bus_din; merr[own] = 1'b0; ph = 2; end
             else if (el >= TMO) begin mdin[own] = 32'd0; merr[own] = 1'b1; ph = 2; end
           end
        default: ph = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int n, input logic [31:0] addr, input logic [3:0] lanes,
                     input logic [31:0] dout, input logic wr);
    m_addr[n] = addr; m_lanes[n] = lanes; m_dout[n] = dout; m_wr[n] = wr; m_valid[n] = 1'b1;
  endtask

  // Called in an IDLE cycle with requester n's request already driven.
  task automatic serve(input int n, input logic [31:0] addr, input logic [3:0] lanes,
                       input logic [31:0] dout, input logic wr, input logic [31:0] rdata);
    tick();
    check("serve bus_valid", 32'(bus_valid), 32'd1);
    check("serve bus_addr",  bus_addr, addr);
    check("serve bus_lanes", 32'(bus_lanes), 32'(lanes));
    check("serve bus_dout",  bus_dout, dout);
    check("serve bus_wr",    32'(bus_wr), 32'(wr));
    check("serve early ready", 32'(d_ready[n]), 32'd0);
    bus_ready = 1'b1; bus_din = rdata;
    tick();
    bus_ready = 1'b0;
    check("serve ready",       32'(d_ready[n]), 32'd1);
    check("serve other ready", 32'(d_ready[1-n]), 32'd0);
    check("serve din",         d_din[n], rdata);
    check("serve err",         32'(d_err[n]), 32'd0);
    tick();
    m_valid[n] = 1'b0;
    check("serve ready pulse end", 32'(d_ready[n]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    for (int n = 0; n < 2; n++) begin
      m_addr[n] = 32'd0; m_lanes[n] = 4'd0; m_dout[n] = 32'd0; m_wr[n] = 1'b0; m_valid[n] = 1'b0;
    end
    bus_ready = 1'b0; bus_din = 32'd0;
    rst = 1'b0;
    repeat (3) tick();
    chk_on = 1'b1;
    check("reset bus_valid", 32'(bus_valid), 32'd0);
    check("reset m0_din",    d_din[0], 32'd0);
    check("reset m1_err",    32'(d_err[1]), 32'd0);
    check("reset m0_ready",  32'(d_ready[0]), 32'd0);
    tick();
    rst = 1'b1;

    // Tie after reset: m0, then m1, then m0 wins the next tie.
    req(0, 32'h10, 4'hF, 32'h0, 1'b0);
    req(1, 32'h20, 4'hF, 32'h0, 1'b0);
    serve(0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hA0A0_0001);
    check("tie gap bus_valid", 32'(bus_valid), 32'd0);
    serve(1, 32'h20, 4'hF, 32'h0, 1'b0, 32'hB0B0_0002);
    req(0, 32'h30, 4'hF, 32'h0, 1'b0);
    req(1, 32'h40, 4'hF, 32'h0, 1'b0);
    serve(0, 32'h30, 4'hF, 32'h0, 1'b0, 32'hA0A0_0003);
    serve(1, 32'h40, 4'hF, 32'h0, 1'b0, 32'hB0B0_0004);

    // Single fetch and store pass-through.
    req(0, 32'h100, 4'hF, 32'h0, 1'b0);
    serve(0, 32'h100, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF);
    check("fetch m0_din held", d_din[0], 32'hDEAD_BEEF);
    req(1, 32'h2000, 4'b0011, 32'h1234, 1'b1);
    serve(1, 32'h2000, 4'b0011, 32'h1234, 1'b1, 32'h5555_5555);

    // Timeout after exactly TMO busy cycles.
    req(0, 32'h300, 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < TMO; i++) begin
      tick();
      check("timeout busy", 32'(bus_valid), 32'd1);
      check("timeout no ready", 32'(d_ready[0]), 32'd0);
    end
    tick();
    check("timeout ready", 32'(d_ready[0]), 32'd1);
    check("timeout err",   32'(d_err[0]), 32'd1);
    check("timeout din",   d_din[0], 32'd0);
    tick();
    m_valid[0] = 1'b0;
    tick();

    // bus_ready on the same cycle the timeout would fire.
    req(0, 32'h304, 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < TMO; i++) tick();
    bus_ready = 1'b1; bus_din = 32'hCAFE_F00D;
    tick();
    bus_ready = 1'b0;
    check("race ready", 32'(d_ready[0]), 32'd1);
    check("race err",   32'(d_err[0]), 32'd0);
    check("race din",   d_din[0], 32'hCAFE_F00D);
    tick();
    m_valid[0] = 1'b0;

    // Reset mid-BUSY with m1 pending.
    req(0, 32'h400, 4'hF, 32'h0, 1'b0);
    tick();
    req(1, 32'h500, 4'h1, 32'h0, 1'b0);
    check("pre-reset bus_valid", 32'(bus_valid), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("reset bus_valid now", 32'(bus_valid), 32'd0);
    check("reset m0_ready now",  32'(d_ready[0]), 32'd0);
    check("reset m0_din now",    d_din[0], 32'd0);
    tick();
    check("reset m1_ready held", 32'(d_ready[1]), 32'd0);
    m_valid[0] = 1'b0;
    rst = 1'b1;
    serve(1, 32'h500, 4'h1, 32'h0, 1'b0, 32'h7777_0000);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst = 1'b0;
      for (int n = 0; n < 2; n++) begin
        if (m_valid[n] && rdy_seen[n]) m_valid[n] = 1'b0;
        else if (!m_valid[n] && $urandom_range(0, 2) == 0)
          req(n, $urandom, 4'($urandom), $urandom, 1'($urandom));
      end
      bus_ready = ($urandom_range(0, 3) == 0);
      bus_din   = $urandom;
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
